// File: rtl/grf_wb.sv
`default_nettype none
// ============================================================================
// Module      : grf_wb
// Description : 31 x 32-bit general register file written from the
//               write-back stage, two combinational decode-stage read ports,
//               and a retire-trace FIFO recording every register write.
//               Optional macro GRF_WB_BYPASS_EN forwards the write-back value
//               to a matching read port in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_wb #(
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_pc,
    input  logic        W_regwe,
    input  logic [4:0]  W_A3,
    input  logic [31:0] W_regwd,
    input  logic [4:0]  D_rs_ad,
    input  logic [4:0]  D_rt_ad,
    output logic [31:0] D_rs_data,
    output logic [31:0] D_rt_data,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [31:0] trace_pc,
    output logic [4:0]  trace_ad,
    output logic [31:0] trace_data,
    output logic        trace_full,
    output logic [7:0]  trace_drop_cnt
);

    localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
    localparam int CNT_W = $clog2(TRACE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(TRACE_DEPTH);

    // Register 0 is never written and stays 0 after reset.
    logic [31:0] regs [32];

    logic [31:0] fifo_pc   [TRACE_DEPTH];
    logic [4:0]  fifo_ad   [TRACE_DEPTH];
    logic [31:0] fifo_data [TRACE_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic wr_en;
    logic empty;
    logic full;
    logic pop;
    logic push;
    logic drop;

    // A retire event is also the register write strobe.
    always_comb begin
        wr_en = W_regwe && (W_A3 != 5'd0);
        empty = (count == '0);
        full  = (count == DEPTH_CNT);
        pop   = !empty && trace_ready;
        // Pushing while full only succeeds if the head leaves on the same edge.
        push  = wr_en && (!full || pop);
        drop  = wr_en && full && !pop;
    end

    // Register file storage; writes are never gated by trace FIFO state.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[W_A3] <= W_regwd;
        end
    end

    // Combinational read ports with optional same-cycle write-back forwarding.
    always_comb begin
        D_rs_data = (D_rs_ad == 5'd0) ? 32'd0 : regs[D_rs_ad];
        D_rt_data = (D_rt_ad == 5'd0) ? 32'd0 : regs[D_rt_ad];
`ifdef GRF_WB_BYPASS_EN
        if (wr_en && (D_rs_ad == W_A3)) begin
            D_rs_data = W_regwd;
        end
        if (wr_en && (D_rt_ad == W_A3)) begin
            D_rt_data = W_regwd;
        end
`endif
    end

    // Trace FIFO payload storage; contents are don't-care while unoccupied.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[tail]   <= W_pc;
            fifo_ad[tail]   <= W_A3;
            fifo_data[tail] <= W_regwd;
        end
    end

    // Trace FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            trace_drop_cnt <= 8'd0;
        end else if (drop && (trace_drop_cnt != 8'hFF)) begin
            trace_drop_cnt <= trace_drop_cnt + 8'd1;
        end
    end

    // Head entry presentation; fields read zero when the FIFO is empty.
    always_comb begin
        trace_valid = !empty;
        trace_full  = full;
        trace_pc    = empty ? 32'd0 : fifo_pc[head];
        trace_ad    = empty ? 5'd0  : fifo_ad[head];
        trace_data  = empty ? 32'd0 : fifo_data[head];
    end

endmodule
`default_nettype wire

// File: tb/tb_grf_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_wb
// Description : Self-checking bench for grf_wb: directed scenarios followed by
//               randomized traffic, compared against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_wb;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] W_pc;
    logic        W_regwe;
    logic [4:0]  W_A3;
    logic [31:0] W_regwd;
    logic [4:0]  D_rs_ad;
    logic [4:0]  D_rt_ad;
    logic [31:0] D_rs_data;
    logic [31:0] D_rt_data;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [4:0]  trace_ad;
    logic [31:0] trace_data;
    logic        trace_full;
    logic [7:0]  trace_drop_cnt;

    grf_wb #(.TRACE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .W_pc           (W_pc),
        .W_regwe        (W_regwe),
        .W_A3           (W_A3),
        .W_regwd        (W_regwd),
        .D_rs_ad        (D_rs_ad),
        .D_rt_ad        (D_rt_ad),
        .D_rs_data      (D_rs_data),
        .D_rt_data      (D_rt_data),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_ad       (trace_ad),
        .trace_data     (trace_data),
        .trace_full     (trace_full),
        .trace_drop_cnt (trace_drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  ad;
        logic [31:0] data;
    } rec_t;

    // Reference model state.
    logic [31:0] m_regs [32];
    rec_t        m_q [$];
    int          m_drop;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] ad);
        logic [31:0] v;
        v = (ad == 5'd0) ? 32'd0 : m_regs[ad];
`ifdef GRF_WB_BYPASS_EN
        if (W_regwe && (W_A3 != 5'd0) && (ad == W_A3)) v = W_regwd;
`endif
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_q.delete();
        m_drop = 0;
    endtask

    // One clock cycle: drive inputs, check outputs mid-cycle, advance model at the edge.
    task automatic cyc(input logic rst, input logic we, input logic [4:0] a3,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic [4:0] rs, input logic [4:0] rt, input logic rdy);
        rec_t head;
        @(negedge clk);
        reset = rst; W_regwe = we; W_A3 = a3; W_regwd = wd; W_pc = pc;
        D_rs_ad = rs; D_rt_ad = rt; trace_ready = rdy;
        #1;
        head = (m_q.size() != 0) ? m_q[0] : '0;
        check("rs_data",    D_rs_data, m_read(rs));
        check("rt_data",    D_rt_data, m_read(rt));
        check("trace_valid", {31'd0, trace_valid}, {31'd0, m_q.size() != 0});
        check("trace_full",  {31'd0, trace_full},  {31'd0, m_q.size() == DEPTH});
        check("trace_pc",    trace_pc,   head.pc);
        check("trace_ad",    {27'd0, trace_ad}, {27'd0, head.ad});
        check("trace_data",  trace_data, head.data);
        check("drop_cnt",    {24'd0, trace_drop_cnt}, 32'(m_drop));
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            if (m_q.size() != 0 && rdy) void'(m_q.pop_front());
            if (we && a3 != 5'd0) begin
                m_regs[a3] = wd;
                if (m_q.size() < DEPTH) m_q.push_back('{pc: pc, ad: a3, data: wd});
                else if (m_drop < 255) m_drop++;
            end
        end
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt, input logic rdy);
        cyc(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, rs, rt, rdy);
    endtask

    task automatic event_w(input logic [4:0] a3, input logic [31:0] wd,
                           input logic [31:0] pc, input logic rdy);
        cyc(1'b0, 1'b1, a3, wd, pc, a3, 5'd0, rdy);
    endtask

    initial begin
        int rdy_pct;
        reset = 1'b1; W_regwe = 1'b0; W_A3 = '0; W_regwd = '0; W_pc = '0;
        D_rs_ad = '0; D_rt_ad = '0; trace_ready = 1'b0;
        m_reset();
        @(posedge clk);
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);

        // Every address reads zero after reset.
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i), 1'b0);

        // Single write appears on the read port and in the trace next cycle.
        event_w(5'd5, 32'h1234_5678, 32'h0000_3000, 1'b0);
        idle(5'd5, 5'd5, 1'b0);
        #1;
        check("req036_rs",  D_rs_data, 32'h1234_5678);
        check("req036_pc",  trace_pc,  32'h0000_3000);
        check("req036_ad",  {27'd0, trace_ad}, 32'd5);

        // Writes to register 0 are ignored and leave no trace record.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h3004, 5'd0, 5'd0, 1'b1);
        idle(5'd0, 5'd5, 1'b0);
        #1;
        check("req037_empty", {31'd0, trace_valid}, 32'd0);

        // Ten events into an eight-deep FIFO with no consumer.
        cyc(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        for (int i = 0; i < 10; i++)
            event_w(5'(i + 1), 32'hA000_0000 + 32'(i), 32'h4000 + 32'(4 * i), 1'b0);
        idle(5'd1, 5'd10, 1'b0);
        #1;
        check("req038_full", {31'd0, trace_full}, 32'd1);
        check("req038_drop", {24'd0, trace_drop_cnt}, 32'd2);
        check("req038_head", trace_pc, 32'h4000);

        // Push and pop on the same edge while full.
        event_w(5'd20, 32'hBEEF_0001, 32'h5000, 1'b1);
        idle(5'd20, 5'd0, 1'b0);
        #1;
        check("req039_full", {31'd0, trace_full}, 32'd1);
        check("req039_drop", {24'd0, trace_drop_cnt}, 32'd2);
        check("req039_head", trace_pc, 32'h4004);
        for (int i = 0; i < DEPTH + 1; i++) idle(5'd0, 5'd0, 1'b1);

        // Same-cycle read of a register being written.
        cyc(1'b0, 1'b1, 5'd9, 32'h0000_00AA, 32'h6000, 5'd0, 5'd9, 1'b1);
        idle(5'd0, 5'd9, 1'b1);

        // Reset mid-operation discards queued records and clears registers.
        event_w(5'd3, 32'h3333, 32'h7000, 1'b0);
        event_w(5'd4, 32'h4444, 32'h7004, 1'b0);
        event_w(5'd3, 32'h3334, 32'h7008, 1'b0);
        cyc(1'b1, 1'b1, 5'd6, 32'h6666, 32'h700C, 5'd3, 5'd4, 1'b1);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(i), 1'b1);

        // Randomized traffic with varying consumer pressure.
        for (int blk = 0; blk < 30; blk++) begin
            rdy_pct = $urandom_range(0, 100);
            for (int i = 0; i < 80; i++) begin
                cyc(($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 99) < 60),
                    5'($urandom_range(0, 31)),
                    $urandom(), $urandom() & 32'hFFFF_FFFC,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 99) < rdy_pct));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
